axi_w_order_m3: RTL and testbench
=================================

# axi_w_order_m3

Write-order tracker for one slave port of the 3-master AXI interconnect. Records the master order of accepted AW transfers. Produces the `w_order_grant` vector consumed by the slave-side master-to-slave mux, so that W bursts reach the slave in AW order. Also checks WLAST placement against the recorded AWLEN and back-pressures AW when its order queue is full.

## Interface

**Parameters**
- `NUM_MASTER`, 3: number of masters. Fixed at 3.
- `DEPTH`, 8: outstanding AW entries. Power of 2, minimum 2.
- `W_PTR`, 3: log2(`DEPTH`).

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `AXI_CLK` in 1: clock.
  - `AXI_RST` in 1: synchronous reset, active-high.
- AW side, from the mux/slave boundary:
  - `AWVALID` in 3: per-master AWVALID, bit i = Mi.
  - `AWREADY` in 3: per-master AWREADY. Already one-hot via the AW grant.
  - `S_AWLEN` in 8: AWLEN currently on the slave AW bus.
- W side:
  - `WVALID` in 3: per-master WVALID.
  - `WREADY` in 3: per-master WREADY.
  - `WLAST` in 3: per-master WLAST.
- Outputs:
  - `w_order_grant` out 3: one-hot master allowed on W; 0 when no entry.
  - `aw_allow` out 1: 0 when the queue is full. The integrator ANDs it into S_AWREADY.
  - `wr_count` out W_PTR+1: occupied entries.
  - `err_wlast` out 1: sticky; WLAST on the wrong beat.
  - `err_aw_multi` out 1: sticky; multi-hot AW handshake seen.

## Operation

- **AW handshake vector:** `aw_hs = AWVALID & AWREADY`.
  - Exactly one bit set → push {master index (2 b), `S_AWLEN`} at `wptr`.
  - More than one bit set → no push; set `err_aw_multi`.
- **Queue:** circular buffer of `DEPTH` entries.
  - `wptr` and `rptr` are W_PTR bits and wrap modulo `DEPTH`.
  - `wr_count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- **Head decode:** `w_order_grant = (wr_count != 0) ? onehot(head.master) : 3'b000`.
- **Beat counter `beat`** (8 b) tracks the head burst.
  - W handshake: `w_hs = WVALID & WREADY & w_order_grant`.
  - Each `w_hs` increments `beat`.
- **Pop:** on `w_hs` with WLAST of the head master set. On pop, `beat` ← 0 and `rptr` advances.
- **WLAST check:**
  - WLAST seen with `beat != head.len` → set `err_wlast`, pop anyway.
  - `beat == head.len` with WLAST low → set `err_wlast`, no pop. Continue counting; `beat` saturates at 255.
- **Full:** `aw_allow = (wr_count != DEPTH)`.
  - Push while full (integrator misuse) is dropped.
  - `wr_count` stays at `DEPTH`.
- **Error flags:** `err_*` clear only on reset.

## Timing

- **Reset:** `wr_count`=0, `wptr`=`rptr`=0, `beat`=0, `w_order_grant`=0, `aw_allow`=1, `err_wlast`=0, `err_aw_multi`=0.
- **Latency:** push is visible on `w_order_grant` the cycle after the AW handshake (queue previously empty). Compiled-in bypass shortens this; see Configuration.
- **Pop:** a pop at edge N exposes the next head at N+1, allowing back-to-back bursts with zero idle cycles.
- **Full and empty at once:** with `DEPTH`=… full plus simultaneous pop, `aw_allow` stays 0 that cycle because it is decoded from the registered count. The push slot opens the next cycle.
- **Reset mid-burst:** all state discarded; outstanding bursts are lost. Masters and the slave are reset together.
- **Combinational dependencies:**
  - `w_order_grant` depends only on registers when bypass is compiled out.
  - `aw_allow` depends only on registers in all configurations.

## Configuration

- Macro: `AXI_W_ORDER_BYPASS_EN`.
- **Defined:** when `wr_count == 0` and `aw_hs` is one-hot, `w_order_grant = aw_hs` in the same cycle.
  - A W handshake in that cycle counts against the pushed entry.
  - If that beat is also WLAST with `S_AWLEN` = 0, push and pop cancel; `wr_count` stays 0.
  - This adds a combinational path from AW ready/valid to the W mux.
- **Undefined:** `w_order_grant` is register-only; 1-cycle AW→W bubble when the queue is empty.

## Test plan

1. **Basic ordering:** AW handshakes M2 (len 1) → M0 (len 0) → M1 (len 3); all WVALID high.
   - `w_order_grant` follows 100, 100, 001, 010×4, then 000.
   - `wr_count` peaks at 3; no errors.
2. **Full:** 8 AW handshakes from M0 with no W.
   - `wr_count`=8 and `aw_allow`=0.
   - One WLAST pop (len 0) → `aw_allow`=1 next cycle.
   - A push in the same cycle as the pop is blocked.
3. **Simultaneous push/pop with wrap:** continuous M1 len 0 traffic for 20 cycles.
   - `wr_count` holds steady; pointers wrap past 7→0; head order preserved.
4. **Early WLAST:** AW M0 len 3; WLAST on beat 1.
   - `err_wlast`=1, entry popped, next head exposed.
5. **Multi-hot AW:** force `aw_hs`=3'b011.
   - `err_aw_multi`=1; `wr_count` unchanged.
6. **Reset mid-burst:** AW M2 len 7, 3 beats, assert `AXI_RST` one cycle.
   - All outputs return to reset values next cycle.
   - With `AXI_W_ORDER_BYPASS_EN`, AW M1 len 0 plus W beat in the same cycle from empty → accepted, `wr_count` stays 0.

Source files
------------

// File: rtl/axi_w_order_m3.sv
// axi_w_order_m3: records master order of accepted AW transfers on one slave port and steers W bursts in that order.
// Optional macro AXI_W_ORDER_BYPASS_EN lets a fresh AW drive w_order_grant in the same cycle when the queue is empty.
module axi_w_order_m3 #(
   parameter int NUM_MASTER = 3,
   parameter int DEPTH      = 8,
   parameter int W_PTR      = 3
) (
   input  logic                  AXI_CLK,
   input  logic                  AXI_RST,
   input  logic [NUM_MASTER-1:0] AWVALID,
   input  logic [NUM_MASTER-1:0] AWREADY,
   input  logic [7:0]            S_AWLEN,
   input  logic [NUM_MASTER-1:0] WVALID,
   input  logic [NUM_MASTER-1:0] WREADY,
   input  logic [NUM_MASTER-1:0] WLAST,
   output logic [NUM_MASTER-1:0] w_order_grant,
   output logic                  aw_allow,
   output logic [W_PTR:0]        wr_count,
   output logic                  err_wlast,
   output logic                  err_aw_multi
);

   localparam logic [W_PTR:0] FULL_CNT = (W_PTR+1)'(DEPTH);

   logic [1:0]            mem_master [DEPTH];
   logic [7:0]            mem_len    [DEPTH];
   logic [W_PTR-1:0]      wptr;
   logic [W_PTR-1:0]      rptr;
   logic [7:0]            beat;

   logic [NUM_MASTER-1:0] aw_hs;
   logic [NUM_MASTER-1:0] w_hs;
   logic [NUM_MASTER-1:0] grant_reg;
   logic                  aw_one;
   logic                  aw_multi;
   logic [1:0]            aw_idx;
   logic                  empty;
   logic                  bypass;
   logic                  push;
   logic                  pop;
   logic                  w_beat;
   logic [7:0]            cur_len;
   logic                  wlast_err;

   assign aw_hs    = AWVALID & AWREADY;
   assign aw_multi = (aw_hs & (aw_hs - 1'b1)) != '0;
   assign aw_one   = (aw_hs != '0) && !aw_multi;
   assign aw_idx   = aw_hs[2] ? 2'd2 : (aw_hs[1] ? 2'd1 : 2'd0);

   assign empty     = (wr_count == '0);
   assign aw_allow  = (wr_count != FULL_CNT);
   assign grant_reg = empty ? '0 : (NUM_MASTER'(1) << mem_master[rptr]);

`ifdef AXI_W_ORDER_BYPASS_EN
   assign bypass = empty && aw_one;
`else
   assign bypass = 1'b0;
`endif

   // While bypassing, the AW being pushed acts as the head for grant and length checks.
   assign w_order_grant = bypass ? aw_hs : grant_reg;
   assign cur_len       = bypass ? S_AWLEN : mem_len[rptr];

   assign w_hs      = WVALID & WREADY & w_order_grant;
   assign w_beat    = |w_hs;
   assign pop       = |(w_hs & WLAST);
   assign push      = aw_one && aw_allow;
   assign wlast_err = (pop && (beat != cur_len)) || (w_beat && !pop && (beat == cur_len));

   always_ff @(posedge AXI_CLK) begin
      if (AXI_RST) begin
         wptr         <= '0;
         rptr         <= '0;
         wr_count     <= '0;
         beat         <= '0;
         err_wlast    <= 1'b0;
         err_aw_multi <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)
            wr_count <= wr_count + 1'b1;
         else if (pop && !push)
            wr_count <= wr_count - 1'b1;
         // A missing WLAST keeps the burst open, so the counter must not wrap back to a valid length.
         if (pop)
            beat <= '0;
         else if (w_beat && (beat != 8'hFF))
            beat <= beat + 1'b1;
         if (wlast_err) err_wlast    <= 1'b1;
         if (aw_multi)  err_aw_multi <= 1'b1;
      end
   end

   always_ff @(posedge AXI_CLK) begin
      if (push) begin
         mem_master[wptr] <= aw_idx;
         mem_len[wptr]    <= S_AWLEN;
      end
   end

endmodule

// File: tb/tb_axi_w_order_m3.sv
// tb_axi_w_order_m3: directed self-checking bench for the AW-order tracker.
// Inputs change 1 time unit after each rising edge; outputs are checked away from the edge.
module tb_axi_w_order_m3;

   logic       AXI_CLK = 1'b0;
   logic       AXI_RST;
   logic [2:0] AWVALID;
   logic [2:0] AWREADY;
   logic [7:0] S_AWLEN;
   logic [2:0] WVALID;
   logic [2:0] WREADY;
   logic [2:0] WLAST;
   logic [2:0] w_order_grant;
   logic       aw_allow;
   logic [3:0] wr_count;
   logic       err_wlast;
   logic       err_aw_multi;

   int pass_count  = 0;
   int check_count = 0;

   logic [2:0] t1_wlast [7] = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010};
   logic [2:0] t1_grant [7] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};

   axi_w_order_m3 dut (
      .AXI_CLK       (AXI_CLK),
      .AXI_RST       (AXI_RST),
      .AWVALID       (AWVALID),
      .AWREADY       (AWREADY),
      .S_AWLEN       (S_AWLEN),
      .WVALID        (WVALID),
      .WREADY        (WREADY),
      .WLAST         (WLAST),
      .w_order_grant (w_order_grant),
      .aw_allow      (aw_allow),
      .wr_count      (wr_count),
      .err_wlast     (err_wlast),
      .err_aw_multi  (err_aw_multi)
   );

   always #5 AXI_CLK = ~AXI_CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [2:0] aw_mask, input logic [7:0] len,
                                input logic [2:0] w_mask, input logic [2:0] wlast);
      AWVALID = aw_mask;
      AWREADY = aw_mask;
      S_AWLEN = len;
      WVALID  = w_mask;
      WREADY  = 3'b111;
      WLAST   = wlast;
      #1;
   endtask

   task automatic tick();
      @(posedge AXI_CLK);
      #1;
   endtask

   initial begin
      logic [2:0] prev;
      logic [2:0] m;

      AXI_RST = 1'b1;
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      tick();
      tick();
      AXI_RST = 1'b0;
      checkOutput("rst_count", wr_count, 0);
      checkOutput("rst_grant", w_order_grant, 0);
      checkOutput("rst_allow", aw_allow, 1);
      checkOutput("rst_err_wlast", err_wlast, 0);
      checkOutput("rst_err_multi", err_aw_multi, 0);

      // Basic ordering: M2 len1, M0 len0, M1 len3, then drain.
      applyStimulus(3'b100, 8'd1, 3'b000, 3'b000); tick();
      applyStimulus(3'b001, 8'd0, 3'b000, 3'b000); tick();
      applyStimulus(3'b010, 8'd3, 3'b000, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t1_count_peak", wr_count, 3);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(3'b000, 8'd0, 3'b111, t1_wlast[i]);
         checkOutput("t1_grant", w_order_grant, t1_grant[i]);
         tick();
      end
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t1_grant_idle", w_order_grant, 0);
      checkOutput("t1_count_end", wr_count, 0);
      checkOutput("t1_err_wlast", err_wlast, 0);
      checkOutput("t1_err_multi", err_aw_multi, 0);

      // Full queue, pop with a blocked push in the same cycle, then drain.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'b001, 8'd0, 3'b000, 3'b000);
         tick();
      end
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t2_count_full", wr_count, 8);
      checkOutput("t2_allow_full", aw_allow, 0);
      applyStimulus(3'b001, 8'd0, 3'b001, 3'b001);
      checkOutput("t2_allow_popcycle", aw_allow, 0);
      tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t2_count_after_pop", wr_count, 7);
      checkOutput("t2_allow_after_pop", aw_allow, 1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(3'b000, 8'd0, 3'b001, 3'b001);
         tick();
      end
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t2_count_drained", wr_count, 0);
      checkOutput("t2_err_wlast", err_wlast, 0);

      // Simultaneous push/pop past the pointer wrap, alternating masters to expose order.
      applyStimulus(3'b010, 8'd0, 3'b000, 3'b000);
      tick();
      prev = 3'b010;
      for (int i = 0; i < 20; i++) begin
         m = (i % 2 == 0) ? 3'b001 : 3'b010;
         applyStimulus(m, 8'd0, 3'b111, 3'b111);
         checkOutput("t3_grant", w_order_grant, prev);
         tick();
         checkOutput("t3_count", wr_count, 1);
         prev = m;
      end
      applyStimulus(3'b000, 8'd0, 3'b111, 3'b111);
      checkOutput("t3_grant_last", w_order_grant, prev);
      tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t3_count_end", wr_count, 0);

      // Early WLAST on beat 1 of a len-3 burst.
      applyStimulus(3'b001, 8'd3, 3'b000, 3'b000); tick();
      applyStimulus(3'b100, 8'd0, 3'b000, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b111, 3'b000); tick();
      checkOutput("t4_err_before", err_wlast, 0);
      applyStimulus(3'b000, 8'd0, 3'b111, 3'b001);
      checkOutput("t4_grant_m0", w_order_grant, 3'b001);
      tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t4_err_wlast", err_wlast, 1);
      checkOutput("t4_count", wr_count, 1);
      checkOutput("t4_next_head", w_order_grant, 3'b100);
      applyStimulus(3'b000, 8'd0, 3'b111, 3'b100); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t4_count_end", wr_count, 0);

      // Multi-hot AW handshake.
      applyStimulus(3'b011, 8'd0, 3'b000, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t5_err_multi", err_aw_multi, 1);
      checkOutput("t5_count", wr_count, 0);

      // Reset in the middle of a burst.
      applyStimulus(3'b100, 8'd7, 3'b000, 3'b000); tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'b000, 8'd0, 3'b100, 3'b000);
         tick();
      end
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t6_count_pre", wr_count, 1);
      checkOutput("t6_grant_pre", w_order_grant, 3'b100);
      AXI_RST = 1'b1;
      tick();
      AXI_RST = 1'b0;
      checkOutput("t6_count", wr_count, 0);
      checkOutput("t6_grant", w_order_grant, 0);
      checkOutput("t6_allow", aw_allow, 1);
      checkOutput("t6_err_wlast", err_wlast, 0);
      checkOutput("t6_err_multi", err_aw_multi, 0);

      // Clean len-1 burst after reset, then one missing its WLAST.
      applyStimulus(3'b001, 8'd1, 3'b000, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b001, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b001, 3'b001); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t7_clean_err", err_wlast, 0);
      checkOutput("t7_clean_count", wr_count, 0);
      applyStimulus(3'b001, 8'd1, 3'b000, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b001, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b001, 3'b000); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t7_missing_err", err_wlast, 1);
      checkOutput("t7_missing_count", wr_count, 1);
      applyStimulus(3'b000, 8'd0, 3'b001, 3'b001); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t7_late_pop_count", wr_count, 0);

      // AW and single-beat W in the same cycle from an empty queue.
      applyStimulus(3'b010, 8'd0, 3'b010, 3'b010);
`ifdef AXI_W_ORDER_BYPASS_EN
      checkOutput("t8_bypass_grant", w_order_grant, 3'b010);
      tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t8_bypass_count", wr_count, 0);
`else
      checkOutput("t8_nobypass_grant", w_order_grant, 0);
      tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t8_nobypass_count", wr_count, 1);
      checkOutput("t8_nobypass_head", w_order_grant, 3'b010);
      applyStimulus(3'b000, 8'd0, 3'b010, 3'b010); tick();
      applyStimulus(3'b000, 8'd0, 3'b000, 3'b000);
      checkOutput("t8_nobypass_drain", wr_count, 0);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
